// File: rtl/game_result_if.sv
`default_nettype none
// ============================================================================
// Module      : game_result_if
// Description : Control and result signals of the two-player round-result
//               controller. The master drives the round-control pulses; the
//               slave (the controller) returns the registered result status.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_result_if;
    logic       start;
    logic       hit_p1;
    logic       hit_p2;
    logic       restart;
    logic [1:0] winner_latched;
    logic       game_active;
    logic       game_over;

    modport master (
        output start,
        output hit_p1,
        output hit_p2,
        output restart,
        input  winner_latched,
        input  game_active,
        input  game_over
    );

    modport slave (
        input  start,
        input  hit_p1,
        input  hit_p2,
        input  restart,
        output winner_latched,
        output game_active,
        output game_over
    );
endinterface
`default_nettype wire

// File: rtl/game_result_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_result_ctrl
// Description : Round-result controller for a two-player crash game. After the
//               first crash a draw window is open; a crash by the other
//               player inside it is a draw, otherwise the survivor wins. The
//               result is held in OVER for a minimum time before restart.
// Revision    : 1.0 - initial release
// ============================================================================
module game_result_ctrl #(
    parameter int DRAW_WINDOW = 650000,
    parameter int HOLD_CYCLES = 65000000
) (
    input  logic         clk,
    input  logic         rst,
    game_result_if.slave bus
);

    localparam int c_WIN_W  = $clog2(DRAW_WINDOW) + 1;
    localparam int c_HOLD_W = $clog2(HOLD_CYCLES) + 1;

    localparam logic [c_WIN_W-1:0]  c_WIN_LAST = c_WIN_W'(DRAW_WINDOW - 1);
    localparam logic [c_WIN_W-1:0]  c_WIN_ONE  = c_WIN_W'(1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(HOLD_CYCLES);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE = c_HOLD_W'(1);

    localparam logic [1:0] c_RES_NONE = 2'b00;
    localparam logic [1:0] c_RES_P1   = 2'b01;
    localparam logic [1:0] c_RES_P2   = 2'b10;
    localparam logic [1:0] c_RES_DRAW = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_WINDOW = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_WIN_W-1:0]  r_win_cnt;
    logic [c_WIN_W-1:0]  w_win_cnt_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_HOLD_W-1:0] w_hold_cnt_nxt;
    logic                r_crashed_p2;     // 1: player 2 crashed first
    logic                w_crashed_p2_nxt;
    logic [1:0]          r_winner;
    logic [1:0]          w_winner_nxt;
    logic                r_active;
    logic                r_over;
    logic                w_opp_hit;
    logic                w_hold_done;

    // A hit from the player who has not yet crashed closes the window as a draw
    assign w_opp_hit   = r_crashed_p2 ? bus.hit_p1 : bus.hit_p2;
    assign w_hold_done = (r_hold_cnt == c_HOLD_MAX);

    // Next-state, counter and result computation for the round FSM
    always_comb begin
        w_state_nxt      = r_state;
        w_win_cnt_nxt    = r_win_cnt;
        w_hold_cnt_nxt   = r_hold_cnt;
        w_crashed_p2_nxt = r_crashed_p2;
        w_winner_nxt     = r_winner;

        case (r_state)
            ST_IDLE: begin
                w_winner_nxt = c_RES_NONE;
                if (bus.start) begin
                    w_state_nxt = ST_PLAY;
                end
            end

            ST_PLAY: begin
                w_winner_nxt = c_RES_NONE;
                if (bus.hit_p1 && bus.hit_p2) begin
                    w_state_nxt    = ST_OVER;
                    w_winner_nxt   = c_RES_DRAW;
                    w_hold_cnt_nxt = '0;
                end else if (bus.hit_p1 || bus.hit_p2) begin
                    w_state_nxt      = ST_WINDOW;
                    w_crashed_p2_nxt = bus.hit_p2;
                    w_win_cnt_nxt    = '0;
                end
            end

            ST_WINDOW: begin
                w_winner_nxt = c_RES_NONE;
                // The opposing hit wins over the timeout, even on the last cycle
                if (w_opp_hit) begin
                    w_state_nxt    = ST_OVER;
                    w_winner_nxt   = c_RES_DRAW;
                    w_hold_cnt_nxt = '0;
                end else if (r_win_cnt == c_WIN_LAST) begin
                    w_state_nxt    = ST_OVER;
                    w_winner_nxt   = r_crashed_p2 ? c_RES_P1 : c_RES_P2;
                    w_hold_cnt_nxt = '0;
                end else begin
                    w_win_cnt_nxt = r_win_cnt + c_WIN_ONE;
                end
            end

            ST_OVER: begin
                if (w_hold_done && bus.restart) begin
                    w_state_nxt      = ST_IDLE;
                    w_winner_nxt     = c_RES_NONE;
                    w_hold_cnt_nxt   = '0;
                    w_win_cnt_nxt    = '0;
                    w_crashed_p2_nxt = 1'b0;
                end else if (!w_hold_done) begin
                    w_hold_cnt_nxt = r_hold_cnt + c_HOLD_ONE;
                end
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_winner_nxt = c_RES_NONE;
            end
        endcase
    end

    // State, counters and registered outputs; reset overrides every input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_win_cnt    <= '0;
            r_hold_cnt   <= '0;
            r_crashed_p2 <= 1'b0;
            r_winner     <= c_RES_NONE;
            r_active     <= 1'b0;
            r_over       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_win_cnt    <= w_win_cnt_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_crashed_p2 <= w_crashed_p2_nxt;
            r_winner     <= w_winner_nxt;
            r_active     <= (w_state_nxt == ST_PLAY) || (w_state_nxt == ST_WINDOW);
            r_over       <= (w_state_nxt == ST_OVER);
        end
    end

    assign bus.winner_latched = r_winner;
    assign bus.game_active    = r_active;
    assign bus.game_over      = r_over;

endmodule
`default_nettype wire

// File: tb/tb_game_result_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_result_ctrl
// Description : Self-checking bench for game_result_ctrl with DRAW_WINDOW=8
//               and HOLD_CYCLES=16. Per-cycle stimulus records carry the
//               hand-derived outputs expected after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_result_ctrl;

    localparam int DW = 8;
    localparam int HC = 16;

    typedef struct {
        logic       rst;
        logic       start;
        logic       h1;
        logic       h2;
        logic       rs;
        logic [1:0] w;
        logic       a;
        logic       o;
    } vec_t;

    typedef struct {
        logic [1:0] w;
        logic       a;
        logic       o;
        int         row;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    vec_t  vecs[$];
    exp_t  expq[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_row   = 0;
    string phase   = "init";

    game_result_if bus();

    game_result_ctrl #(
        .DRAW_WINDOW (DW),
        .HOLD_CYCLES (HC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, s, h1, h2, rs, input logic [1:0] w, input logic a, o);
        vec_t v;
        v.rst = r; v.start = s; v.h1 = h1; v.h2 = h2; v.rs = rs;
        v.w = w; v.a = a; v.o = o;
        vecs.push_back(v);
    endtask

    task automatic check_one();
        exp_t e;
        n_tests++;
        if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: no expected entry, got w=%b a=%b o=%b",
                     bus.winner_latched, bus.game_active, bus.game_over);
        end else begin
            e = expq.pop_front();
            if (bus.winner_latched !== e.w || bus.game_active !== e.a || bus.game_over !== e.o) begin
                n_fail++;
                $display("FAIL %s row %0d: got w=%b a=%b o=%b, expected w=%b a=%b o=%b",
                         phase, e.row, bus.winner_latched, bus.game_active, bus.game_over,
                         e.w, e.a, e.o);
            end
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst         = v.rst;
        bus.start   = v.start;
        bus.hit_p1  = v.h1;
        bus.hit_p2  = v.h2;
        bus.restart = v.rs;
        e.w = v.w; e.a = v.a; e.o = v.o; e.row = n_row;
        expq.push_back(e);
        n_row++;
        @(posedge clk);
        #1;
        check_one();
    endtask

    task automatic cyc(input logic r, s, h1, h2, rs, input logic [1:0] w, input logic a, o);
        vec_t v;
        v.rst = r; v.start = s; v.h1 = h1; v.h2 = h2; v.rs = rs;
        v.w = w; v.a = a; v.o = o;
        apply(v);
    endtask

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.hit_p1 = 1'b0; bus.hit_p2 = 1'b0; bus.restart = 1'b0;

        // ---------------- table: reset, IDLE, repeat-hit, draws, p2 alone
        add(1,0,0,0,0, 2'b00,0,0);
        add(1,1,1,1,1, 2'b00,0,0);           // reset beats start
        add(0,0,1,0,0, 2'b00,0,0);           // hits ignored in IDLE
        add(0,0,0,1,0, 2'b00,0,0);
        add(0,0,1,1,1, 2'b00,0,0);           // restart ignored in IDLE
        add(0,1,0,0,0, 2'b00,1,0);           // start -> PLAY
        add(0,0,0,0,1, 2'b00,1,0);           // restart ignored in PLAY
        add(0,1,0,0,0, 2'b00,1,0);           // start ignored in PLAY
        add(0,0,1,0,0, 2'b00,1,0);           // p1 crash -> WINDOW, cnt 0
        for (int i = 1; i <= 7; i++) add(0,0,1,0,0, 2'b00,1,0);   // repeats, cnt 0..6
        add(0,0,1,0,0, 2'b10,0,1);           // cnt 7 -> p2 wins, no restart of counter
        add(1,0,0,0,0, 2'b00,0,0);
        add(0,1,0,0,0, 2'b00,1,0);           // simultaneous crash
        add(0,0,1,1,0, 2'b11,0,1);
        add(1,1,0,0,0, 2'b00,0,0);           // reset priority over start
        add(0,1,0,0,0, 2'b00,1,0);
        add(0,0,0,1,0, 2'b00,1,0);           // p2 crash, cnt 0
        add(0,1,0,0,0, 2'b00,1,0);           // start ignored in WINDOW
        add(0,0,0,0,1, 2'b00,1,0);           // restart ignored in WINDOW
        add(0,0,1,0,0, 2'b11,0,1);           // p1 three cycles later -> draw
        add(0,0,1,1,0, 2'b11,0,1);           // hits ignored in OVER
        add(0,1,0,0,0, 2'b11,0,1);           // start ignored in OVER
        add(1,0,0,0,0, 2'b00,0,0);
        add(0,1,0,0,0, 2'b00,1,0);           // opposing hit on final window cycle
        add(0,0,0,1,0, 2'b00,1,0);
        for (int i = 0; i < 7; i++) add(0,0,0,(i == 3),0, 2'b00,1,0);
        add(0,0,1,0,0, 2'b11,0,1);
        add(1,0,0,0,0, 2'b00,0,0);
        add(0,1,0,0,0, 2'b00,1,0);           // p2 alone -> p1 wins
        add(0,0,0,1,0, 2'b00,1,0);
        for (int i = 0; i < 7; i++) add(0,0,0,0,0, 2'b00,1,0);
        add(0,0,0,0,0, 2'b01,0,1);
        add(0,0,0,0,0, 2'b01,0,1);           // result held
        add(1,0,0,0,0, 2'b00,0,0);

        phase = "table";
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // ---------------- p1 alone, then restart gating in OVER
        phase = "timeout_hold";
        cyc(0,1,0,0,0, 2'b00,1,0);
        cyc(0,0,1,0,0, 2'b00,1,0);
        for (int i = 0; i < 7; i++) cyc(0,0,0,0,0, 2'b00,1,0);
        cyc(0,0,0,0,0, 2'b10,0,1);           // OVER entry, hold 0
        for (int j = 0; j < 5; j++) cyc(0,(j == 2),(j == 3),(j == 3),0, 2'b10,0,1);
        cyc(0,0,0,0,1, 2'b10,0,1);           // restart at hold 5 ignored
        for (int j = 6; j < 15; j++) cyc(0,0,0,0,0, 2'b10,0,1);
        cyc(0,0,0,0,1, 2'b10,0,1);           // restart at hold 15 ignored
        cyc(0,0,0,0,1, 2'b00,0,0);           // restart at hold 16 accepted
        cyc(0,0,0,0,0, 2'b00,0,0);

        // ---------------- reset mid-WINDOW, counter and crash record cleared
        phase = "rst_window";
        cyc(0,1,0,0,0, 2'b00,1,0);
        cyc(0,0,1,0,0, 2'b00,1,0);
        for (int i = 0; i < 3; i++) cyc(0,0,0,0,0, 2'b00,1,0);
        cyc(1,0,0,0,0, 2'b00,0,0);
        cyc(0,1,0,0,0, 2'b00,1,0);           // start right after reset release
        cyc(0,0,0,1,0, 2'b00,1,0);
        for (int i = 0; i < 7; i++) cyc(0,0,0,0,0, 2'b00,1,0);
        cyc(0,0,0,0,0, 2'b01,0,1);

        // ---------------- reset mid-OVER
        phase = "rst_over";
        cyc(0,0,0,0,0, 2'b01,0,1);
        cyc(0,0,0,0,1, 2'b01,0,1);
        cyc(1,0,0,0,1, 2'b00,0,0);
        cyc(0,1,0,0,0, 2'b00,1,0);
        cyc(0,0,0,0,0, 2'b00,1,0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
